// File: rtl/pc_lut_loader_if.sv
// pc_lut_loader_if: load-stream handshake, status and fetch read port of the
// branch-target table loader.
//   start        - one-cycle load request (sampled in IDLE)
//   in_valid     - byte present on in_data
//   in_data      - stream byte
//   in_ready     - loader accepts a byte this cycle
//   busy         - loader is not in IDLE
//   done         - one-cycle pulse when a load completes
//   err          - sticky checksum error
//   addr         - fetch read index
//   target       - table[addr], combinational
//   target_valid - valid[addr], combinational
// master: the side that drives the stream and the read index.
// slave:  the loader itself.
interface pc_lut_loader_if #(
  parameter int unsigned D = 10
);
  logic         start;
  logic         in_valid;
  logic [7:0]   in_data;
  logic         in_ready;
  logic         busy;
  logic         done;
  logic         err;
  logic [3:0]   addr;
  logic [D-1:0] target;
  logic         target_valid;

  modport master (
    output start, in_valid, in_data, addr,
    input  in_ready, busy, done, err, target, target_valid
  );

  modport slave (
    input  start, in_valid, in_data, addr,
    output in_ready, busy, done, err, target, target_valid
  );
endinterface

// File: rtl/pc_lut_loader.sv
// pc_lut_loader: programmable 16-entry branch-target table with a byte-serial
// load port. Entries arrive as little-endian byte pairs (low byte, then high
// byte); only the low D-8 bits of the high byte are stored. The fetch read
// port (addr -> target, target_valid) is combinational.
// Ports:
//   clk_i - clock, all state updates on the rising edge
//   rst_i - asynchronous active-high reset, clears all state
//   bus   - pc_lut_loader_if.slave (stream, status, read port)
// Build option: define PC_LUT_LOADER_CHECKSUM_EN to require a trailing XOR
// checksum byte after the 32 data bytes; a mismatch sets err and invalidates
// every entry. Without it err is tied low.
module pc_lut_loader #(
  parameter int unsigned D = 10,
  parameter int unsigned N = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  pc_lut_loader_if.slave bus
);

  localparam int unsigned IDX_W = 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LO,
    S_HI,
`ifdef PC_LUT_LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       lo_q, lo_d;
  logic [N-1:0]     valid_q, valid_d;
  logic [D-1:0]     tbl_q [N];
  logic             tbl_we;
  logic [D-1:0]     tbl_wdata;
  logic             in_ready_c;
  logic             accept_c;
`ifdef PC_LUT_LOADER_CHECKSUM_EN
  logic             err_q, err_d;
  logic [7:0]       xor_q, xor_d;
`endif

  // Ready is decoded from state alone so in_valid never reaches in_ready.
  always_comb begin
    in_ready_c = 1'b0;
    case (state_q)
      S_LO, S_HI: in_ready_c = 1'b1;
`ifdef PC_LUT_LOADER_CHECKSUM_EN
      S_CHECK:    in_ready_c = 1'b1;
`endif
      default:    in_ready_c = 1'b0;
    endcase
  end

  assign accept_c  = bus.in_valid && in_ready_c;
  assign tbl_wdata = {bus.in_data[D-9:0], lo_q};

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lo_d    = lo_q;
    valid_d = valid_q;
    tbl_we  = 1'b0;
`ifdef PC_LUT_LOADER_CHECKSUM_EN
    err_d   = err_q;
    xor_d   = xor_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_LO;
          idx_d   = '0;
          valid_d = '0;
`ifdef PC_LUT_LOADER_CHECKSUM_EN
          err_d   = 1'b0;
          xor_d   = '0;
`endif
        end
      end
      S_LO: begin
        if (accept_c) begin
          lo_d    = bus.in_data;
`ifdef PC_LUT_LOADER_CHECKSUM_EN
          xor_d   = xor_q ^ bus.in_data;
`endif
          state_d = S_HI;
        end
      end
      S_HI: begin
        if (accept_c) begin
          tbl_we         = 1'b1;
          valid_d[idx_q] = 1'b1;
`ifdef PC_LUT_LOADER_CHECKSUM_EN
          xor_d          = xor_q ^ bus.in_data;
`endif
          if (idx_q == LAST_IDX) begin
`ifdef PC_LUT_LOADER_CHECKSUM_EN
            state_d = S_CHECK;
`else
            state_d = S_DONE;
`endif
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_LO;
          end
        end
      end
`ifdef PC_LUT_LOADER_CHECKSUM_EN
      // Bad checksum keeps the table data but hides every entry from fetch.
      S_CHECK: begin
        if (accept_c) begin
          if (bus.in_data != xor_q) begin
            err_d   = 1'b1;
            valid_d = '0;
          end
          state_d = S_DONE;
        end
      end
`endif
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      lo_q    <= '0;
      valid_q <= '0;
`ifdef PC_LUT_LOADER_CHECKSUM_EN
      err_q   <= 1'b0;
      xor_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lo_q    <= lo_d;
      valid_q <= valid_d;
`ifdef PC_LUT_LOADER_CHECKSUM_EN
      err_q   <= err_d;
      xor_q   <= xor_d;
`endif
    end
  end

  // Target table storage.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(N); i++) begin
        tbl_q[i] <= '0;
      end
    end else if (tbl_we) begin
      tbl_q[idx_q] <= tbl_wdata;
    end
  end

  assign bus.in_ready     = in_ready_c;
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.done         = (state_q == S_DONE);
`ifdef PC_LUT_LOADER_CHECKSUM_EN
  assign bus.err          = err_q;
`else
  assign bus.err          = 1'b0;
`endif
  assign bus.target       = tbl_q[bus.addr];
  assign bus.target_valid = valid_q[bus.addr];

endmodule
